// File: rtl/dec_rkey_buf_if.sv
// Round-key load and decryption-schedule read bundle between key expansion,
// the schedule buffer and the decryption datapath.
interface dec_rkey_buf_if;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_round;
  logic [127:0] in_key;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         keys_ready;
  logic         err;

  modport master (
    output start, in_valid, in_round, in_key, rd_en, rd_round,
    input  in_ready, rd_key, rd_valid, keys_ready, err
  );

  modport slave (
    input  start, in_valid, in_round, in_key, rd_en, rd_round,
    output in_ready, rd_key, rd_valid, keys_ready, err
  );
endinterface

// File: rtl/dec_rkey_buf.sv
// Buffers encryption round keys and serves them as the equivalent-inverse-cipher
// decryption schedule; zero load latency, registered 1-cycle read port.
module dec_rkey_buf #(
  parameter int NR = 10
) (
  input logic           clk,
  input logic           rst_n,
  dec_rkey_buf_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [3:0] NR_L    = 4'(NR);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; byte 0 is the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      b[i]   = w[31-8*i -: 8];
      x2     = xt(b[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ b[i];
      m11[i] = x8 ^ x2 ^ b[i];
      m13[i] = x8 ^ x4 ^ b[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [127:0] key_eic(input logic [127:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   exp_r_q, exp_r_d;
  logic         err_q, err_d;
  logic [127:0] rd_key_q, rd_key_d;
  logic         rd_valid_q, rd_valid_d;
  logic [127:0] mem_q [0:NR];

  logic         xfer, wr_en, rd_ok;
  logic [3:0]   wr_slot;
  logic [127:0] wr_dat;

  always_comb begin
    xfer    = bus.in_valid && (state_q == ST_LOAD) && !bus.start;
    wr_en   = xfer && (bus.in_round == exp_r_q) && (bus.in_round <= NR_L);
    wr_slot = NR_L - bus.in_round;
    wr_dat  = ((bus.in_round == 4'd0) || (bus.in_round == NR_L)) ? bus.in_key
                                                                  : key_eic(bus.in_key);
    rd_ok   = bus.rd_en && (state_q == ST_DONE) && (bus.rd_round <= NR_L);

    state_d    = state_q;
    exp_r_d    = exp_r_q;
    err_d      = err_q;
    rd_valid_d = rd_ok;
    rd_key_d   = rd_ok ? mem_q[bus.rd_round] : rd_key_q;

    // start overrides any transfer presented in the same cycle
    if (bus.start) begin
      state_d = ST_LOAD;
      exp_r_d = 4'd0;
      err_d   = 1'b0;
    end else if (wr_en) begin
      exp_r_d = exp_r_q + 4'd1;
      if (bus.in_round == NR_L) state_d = ST_DONE;
    end else if (xfer) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      exp_r_q    <= 4'd0;
      err_q      <= 1'b0;
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_r_q    <= exp_r_d;
      err_q      <= err_d;
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Slot contents are only observable once a full in-order load has completed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_slot] <= wr_dat;
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.keys_ready = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.rd_key     = rd_key_q;
  assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_dec_rkey_buf.sv
// Bench for dec_rkey_buf: directed corner sequences, a read table and a
// randomized run, all against a queue-based reference model.
module tb_dec_rkey_buf;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dec_rkey_buf_if bus();

  dec_rkey_buf #(.NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the accepted encryption keys in arrival order.
  logic [127:0] ek_q [$];
  bit           m_loading;
  bit           m_err;
  bit           m_rd_valid;
  logic [127:0] m_rd_key;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0] coef [4];
    logic [7:0] acc;
    coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    r = '0;
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - i) & 3], k[127 - 32*w - 8*j -: 8]);
        r[127 - 32*w - 8*i -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] ref_key(input int r);
    if (r == 0)  return ek_q[NR];
    if (r == NR) return ek_q[0];
    return inv_mix(ek_q[NR - r]);
  endfunction

  task automatic model_reset();
    ek_q.delete();
    m_loading  = 0;
    m_err      = 0;
    m_rd_valid = 0;
    m_rd_key   = '0;
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Advance one clock: model consumes the inputs held across the edge, then
  // every output is compared #1 after the edge.
  task automatic step();
    bit kr;
    kr = (ek_q.size() == NR + 1);
    if (rst_n) begin
      if (bus.rd_en && kr && int'(bus.rd_round) <= NR) begin
        m_rd_valid = 1;
        m_rd_key   = ref_key(int'(bus.rd_round));
      end else begin
        m_rd_valid = 0;
      end
      if (bus.start) begin
        m_loading = 1;
        m_err     = 0;
        ek_q.delete();
      end else if (m_loading && bus.in_valid) begin
        if (int'(bus.in_round) == ek_q.size()) begin
          ek_q.push_back(bus.in_key);
          if (ek_q.size() == NR + 1) m_loading = 0;
        end else begin
          m_err     = 1;
          m_loading = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    chk("in_ready",   128'(bus.in_ready),   128'(m_loading));
    chk("keys_ready", 128'(bus.keys_ready), 128'(ek_q.size() == NR + 1));
    chk("err",        128'(bus.err),        128'(m_err));
    chk("rd_valid",   128'(bus.rd_valid),   128'(m_rd_valid));
    chk("rd_key",     bus.rd_key,           m_rd_key);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input int r, input logic [127:0] k);
    bus.in_valid = 1'b1;
    bus.in_round = 4'(r);
    bus.in_key   = k;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic rd(input int r);
    bus.rd_en    = 1'b1;
    bus.rd_round = 4'(r);
    step();
    bus.rd_en    = 1'b0;
  endtask

  function automatic logic [127:0] tbl_key(input int r);
    if (r == 3) return {4{32'h8e4da1bc}};
    return {16{8'(8'h10 + r)}};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    bit           rd_en;
    logic [3:0]   rd_round;
    bit           exp_vld;
    logic [127:0] exp_key;
  } vec_t;

  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 4'd7,  1'b1, {4{32'hdb135345}}};
    vt[1] = '{1'b1, 4'd0,  1'b1, {16{8'h1a}}};
    vt[2] = '{1'b1, 4'd10, 1'b1, {16{8'h10}}};
    vt[3] = '{1'b1, 4'd11, 1'b0, {16{8'h10}}};
    vt[4] = '{1'b1, 4'd5,  1'b1, {16{8'h15}}};
    vt[5] = '{1'b0, 4'd5,  1'b0, {16{8'h15}}};
    vt[6] = '{1'b1, 4'd3,  1'b1, {16{8'h17}}};
    vt[7] = '{1'b1, 4'd15, 1'b0, {16{8'h17}}};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_round = 4'd0;
    bus.in_key   = '0;
    bus.rd_en    = 1'b0;
    bus.rd_round = 4'd0;
    model_reset();
    #12;
    chk("rst in_ready",   128'(bus.in_ready),   128'(0));
    chk("rst keys_ready", 128'(bus.keys_ready), 128'(0));
    chk("rst err",        128'(bus.err),        128'(0));
    chk("rst rd_valid",   128'(bus.rd_valid),   128'(0));
    chk("rst rd_key",     bus.rd_key,           128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All-0x5A load: every schedule entry stays 0x5A.
    rd(2);
    chk("read before load", 128'(bus.rd_valid), 128'(0));
    do_start();
    for (int r = 0; r <= NR; r++) send(r, {16{8'h5a}});
    chk("5a keys_ready", 128'(bus.keys_ready), 128'(1));
    chk("5a in_ready",   128'(bus.in_ready),   128'(0));
    bus.rd_en = 1'b1;
    for (int r = 0; r <= NR; r++) begin
      bus.rd_round = 4'(r);
      step();
      chk("5a rd_valid", 128'(bus.rd_valid), 128'(1));
      chk("5a rd_key",   bus.rd_key,         {16{8'h5a}});
    end
    bus.rd_en = 1'b0;

    // Table-driven reads over a known schedule.
    do_start();
    for (int r = 0; r <= NR; r++) send(r, tbl_key(r));
    for (int i = 0; i < 8; i++) begin
      bus.rd_en    = vt[i].rd_en;
      bus.rd_round = vt[i].rd_round;
      step();
      chk($sformatf("tbl%0d rd_valid", i), 128'(bus.rd_valid), 128'(vt[i].exp_vld));
      chk($sformatf("tbl%0d rd_key", i),   bus.rd_key,          vt[i].exp_key);
    end
    bus.rd_en = 1'b0;

    // Out-of-order round aborts the load.
    do_start();
    for (int r = 0; r < 3; r++) send(r, rnd128());
    send(4, rnd128());
    chk("ooo err",        128'(bus.err),        128'(1));
    chk("ooo in_ready",   128'(bus.in_ready),   128'(0));
    chk("ooo keys_ready", 128'(bus.keys_ready), 128'(0));
    send(3, rnd128());
    chk("ooo sticky err", 128'(bus.err), 128'(1));
    do_start();
    chk("start clears err", 128'(bus.err), 128'(0));
    for (int r = 0; r <= NR; r++) send(r, rnd128());
    chk("reload keys_ready", 128'(bus.keys_ready), 128'(1));

    // start coincident with the round-5 transfer drops it.
    do_start();
    for (int r = 0; r < 5; r++) send(r, rnd128());
    bus.start = 1'b1;
    send(5, rnd128());
    bus.start = 1'b0;
    chk("coinc in_ready", 128'(bus.in_ready), 128'(1));
    chk("coinc err",      128'(bus.err),      128'(0));
    send(6, rnd128());
    chk("coinc round6 err", 128'(bus.err), 128'(1));

    // Asynchronous reset in the middle of a load.
    do_start();
    for (int r = 0; r <= 6; r++) send(r, rnd128());
    rst_n = 1'b0;
    #1;
    chk("arst in_ready",   128'(bus.in_ready),   128'(0));
    chk("arst keys_ready", 128'(bus.keys_ready), 128'(0));
    chk("arst err",        128'(bus.err),        128'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(7, rnd128());
    rd(1);
    chk("arst read", 128'(bus.rd_valid), 128'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      bus.start    = (!m_loading && ($urandom % 8 == 0)) || ($urandom % 300 == 0);
      bus.in_valid = ($urandom % 4 != 0);
      bus.in_round = ($urandom % 50 == 0) ? 4'($urandom % 16) : 4'(ek_q.size());
      bus.in_key   = rnd128();
      bus.rd_en    = ($urandom % 2 == 0);
      bus.rd_round = 4'($urandom_range(0, 12));
      step();
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
